// File: rtl/capstone_pkg.sv
// Shared types and constants for the capstone fetch/decode slice.
// The end-of-program flag lives in the top bit of every program word.
package capstone_pkg;

  localparam int OP_W    = 3;
  localparam int INSTR_W = 32;
  localparam int END_BIT = 31;

  typedef enum logic [OP_W-1:0] {
    OP_PROC     = 3'b000,
    OP_LOAD_W   = 3'b001,
    OP_LOAD_A   = 3'b010,
    OP_STORE    = 3'b011,
    OP_SYNC     = 3'b100,
    OP_LOAD_DNN = 3'b101
  } opcode_t;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t IDLE  = 2'd0;
  localparam fetch_state_t FETCH = 2'd1;
  localparam fetch_state_t DRAIN = 2'd2;

  function automatic logic is_end_word(input logic [INSTR_W-1:0] word);
    return word[END_BIT];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular prefetch FIFO; the head entry is read straight from a storage
// register so instr/instr_valid carry no combinational path from memory.
module fetch_fifo #(
  parameter  int W     = 32,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  input  logic             flush,
  output logic [W-1:0]     dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: storage is reset too; it is only DEPTH words and instr must read 0 out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same edge, order-independent.
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues ordered reads from base_addr, buffers up to DEPTH words
// and hands them to decode until the end-flag word has been consumed.
module instr_fetch
  import capstone_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  outstanding, out_nxt, fifo_cnt;
  logic [CNT_W:0]    occupancy;
  logic              end_seen, fifo_empty, fifo_full;
  logic              fire, push, pop, flush, end_in, prog_done;

  assign busy        = (state != IDLE);
  assign mem_addr    = pc;
  assign instr_valid = !fifo_empty;
  assign pop         = instr_valid && instr_ready;
  assign flush       = (state == FETCH) && abort;
  assign push        = (state == FETCH) && mem_rvalid && !end_seen && !abort;
  assign end_in      = push && is_end_word(mem_rdata);

  // A slot vacated by this cycle's pop is credited immediately, which is what
  // lets a DEPTH=2 FIFO sustain one instruction per cycle at zero wait states.
  // Once the gate opens it stays open until granted: pushes only move a word
  // from outstanding into the FIFO, so occupancy can only fall meanwhile.
  assign occupancy = {1'b0, outstanding} + {1'b0, fifo_cnt} - (CNT_W + 1)'(pop);
  assign mem_req   = (state == FETCH) && !end_seen && !end_in &&
                     (occupancy < (CNT_W + 1)'(DEPTH));
  assign fire      = mem_req && mem_gnt;

  always_comb begin
    // NOTE: defaults first in always_comb, so no path can leave a signal unassigned and infer a latch.
    out_nxt   = outstanding + CNT_W'(fire) - CNT_W'(mem_rvalid);
    prog_done = 1'b0;
    if (end_seen && out_nxt == '0)
      prog_done = (fifo_cnt == '0) || (fifo_cnt == CNT_W'(1) && pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      outstanding <= '0;
      end_seen    <= 1'b0;
      done        <= 1'b0;
    end else begin
      done        <= 1'b0;
      outstanding <= out_nxt;
      if (fire)   pc       <= pc + ADDR_W'(4);
      if (end_in) end_seen <= 1'b1;
      case (state)
        IDLE: if (start) begin
          state    <= FETCH;
          pc       <= base_addr;
          end_seen <= 1'b0;
        end
        FETCH: begin
          if (abort) state <= DRAIN;
          else if (prog_done) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        DRAIN:   if (out_nxt == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  fetch_fifo #(.W(INSTR_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (mem_rdata),
    .pop   (pop),
    .flush (flush),
    .dout  (instr),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_cnt)
  );

  assert property (@(posedge clk) disable iff (rst) !(mem_rvalid && outstanding == '0));
  assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a latency-programmable memory model plus
// address and instruction scoreboards filled when each program is launched.
module tb_instr_fetch;
  import capstone_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, abort, busy, done;
  logic [ADDR_W-1:0] base_addr, mem_addr;
  logic              mem_req, mem_gnt, mem_rvalid;
  logic [31:0]       mem_rdata, instr;
  logic              instr_valid, instr_ready;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .abort(abort),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct { logic [31:0] addr; int due; } pend_t;

  logic [31:0] prog [16];
  int          lat_arr [16];
  bit          gnt_en;
  int          cyc, fires, rvalids, pops, dones, first_pop, last_pop, done_cyc;
  pend_t       pend [$];
  logic [31:0] exp_addr [$];
  logic [31:0] exp_instr [$];

  // Memory model: in-order responses, per-word latency, grant policy from gnt_en.
  initial begin
    pend_t p;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; cyc = 0; fires = 0; rvalids = 0;
    forever begin
      @(negedge clk);
      cyc++;
      mem_rvalid = 0;
      mem_rdata  = '0;
      if (rst) begin
        pend.delete();
        mem_gnt = 0;
      end else begin
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          p = pend.pop_front();
          mem_rvalid = 1;
          mem_rdata  = prog[p.addr[5:2]];
          rvalids++;
        end
        mem_gnt = gnt_en;
        #1;
        if (mem_req && mem_gnt) begin
          fires++;
          pend.push_back('{addr: mem_addr, due: cyc + lat_arr[mem_addr[5:2]]});
          if (exp_addr.size() > 0) check("req_addr", mem_addr, exp_addr.pop_front());
          else check("unexpected_req", mem_req, 0);
        end
      end
    end
  end

  // Output monitor: instruction scoreboard, hold stability, done/busy exclusivity.
  initial begin
    bit          hold_valid = 0;
    logic [31:0] hold_instr = '0;
    pops = 0; dones = 0; first_pop = -1; last_pop = -1; done_cyc = -1;
    forever begin
      @(negedge clk);
      #2;
      if (rst) hold_valid = 0;
      else begin
        if (hold_valid && instr_valid) check("instr_stable", instr, hold_instr);
        if (done) begin
          dones++;
          done_cyc = cyc;
          check("done_not_busy", busy, 0);
        end
        if (instr_valid && instr_ready) begin
          pops++;
          if (first_pop < 0) first_pop = cyc;
          last_pop = cyc;
          if (exp_instr.size() > 0) check("instr", instr, exp_instr.pop_front());
          else check("extra_instr", instr_valid, 0);
        end
        hold_valid = instr_valid && !instr_ready;
        hold_instr = instr;
      end
    end
  end

  task automatic launch(input logic [31:0] base, input int n_req, input int n_instr);
    logic [31:0] a;
    for (int i = 0; i < n_req; i++) begin
      a = base + 32'(4 * i);
      exp_addr.push_back(a);
      if (i < n_instr) exp_instr.push_back(prog[a[5:2]]);
    end
    first_pop = -1;
    @(negedge clk);
    base_addr = base;
    start = 1;
    @(negedge clk);
    start = 0;
    #3;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (busy) check({tag, "_timeout"}, busy, 0);
  endtask

  task automatic scoreboard_empty(input string tag);
    check({tag, "_addr_left"}, exp_addr.size(), 0);
    check({tag, "_instr_left"}, exp_instr.size(), 0);
    exp_addr.delete();
    exp_instr.delete();
  endtask

  task automatic load_t1;
    prog[0] = 32'h0000_0011; prog[1] = 32'h0000_0022;
    prog[2] = 32'h0000_0033; prog[3] = 32'h8000_0044;
  endtask

  initial begin
    int f0, p0, d0, r0, n;
    rst = 1; start = 0; abort = 0; base_addr = '0; instr_ready = 1; gnt_en = 1;
    for (int i = 0; i < 16; i++) begin prog[i] = 32'h0; lat_arr[i] = 1; end
    repeat (2) @(negedge clk);
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    @(negedge clk);
    rst = 0;

    // 1: zero-wait streaming
    load_t1();
    p0 = pops; d0 = dones; f0 = fires;
    launch(32'h100, 4, 4);
    wait_idle("t1", 40);
    check("t1_pops", pops - p0, 4);
    check("t1_dones", dones - d0, 1);
    check("t1_fires", fires - f0, 4);
    check("t1_back_to_back", last_pop - first_pop, 3);
    check("t1_done_latency", done_cyc - last_pop, 1);
    scoreboard_empty("t1");

    // 2: decode backpressure
    for (int i = 0; i < 6; i++) prog[i] = 32'h0000_0200 + 32'(i);
    prog[5] = 32'h8000_0205;
    instr_ready = 0;
    p0 = pops; d0 = dones; f0 = fires;
    launch(32'h200, 6, 6);
    repeat (10) @(negedge clk);
    #3;
    check("bp_fires", fires - f0, DEPTH);
    check("bp_req_low", mem_req, 0);
    check("bp_valid", instr_valid, 1);
    @(negedge clk);
    instr_ready = 1;
    wait_idle("t2", 60);
    check("t2_pops", pops - p0, 6);
    check("t2_dones", dones - d0, 1);
    scoreboard_empty("t2");

    // 3: end flag with the next word already granted
    prog[0] = 32'h8000_00AA; prog[1] = 32'h0000_00BB;
    lat_arr[0] = 2; lat_arr[1] = 2;
    p0 = pops; d0 = dones; f0 = fires;
    launch(32'h300, 2, 1);
    wait_idle("t3", 40);
    check("t3_fires", fires - f0, 2);
    check("t3_pops", pops - p0, 1);
    check("t3_dones", dones - d0, 1);
    scoreboard_empty("t3");

    // 4: abort with one word stored and one read in flight
    for (int i = 0; i < 4; i++) prog[i] = 32'h0000_0400 + 32'(i);
    lat_arr[0] = 1; lat_arr[1] = 5;
    instr_ready = 0;
    p0 = pops; d0 = dones; f0 = fires; r0 = rvalids;
    launch(32'h400, 2, 0);
    n = 0;
    while (!instr_valid && n < 20) begin @(negedge clk); #3; n++; end
    check("t4_valid_seen", instr_valid, 1);
    abort = 1;
    @(negedge clk);
    abort = 0;
    #3;
    check("abort_valid_drop", instr_valid, 0);
    check("abort_draining", busy, 1);
    check("abort_req_low", mem_req, 0);
    wait_idle("t4", 40);
    check("t4_fires", fires - f0, 2);
    check("t4_rvalids", rvalids - r0, 2);
    check("t4_pops", pops - p0, 0);
    check("t4_no_done", dones - d0, 0);
    scoreboard_empty("t4");
    instr_ready = 1;
    lat_arr[1] = 1;

    // 4b: an ungranted request is withdrawn by abort
    gnt_en = 0;
    d0 = dones;
    launch(32'h500, 0, 0);
    repeat (2) @(negedge clk);
    #3;
    check("held_req", mem_req, 1);
    check("held_addr", mem_addr, 32'h500);
    abort = 1;
    @(negedge clk);
    abort = 0;
    #3;
    check("withdrawn_req", mem_req, 0);
    wait_idle("t4b", 10);
    check("t4b_no_done", dones - d0, 0);
    gnt_en = 1;

    // 5: address wrap at the top of the byte-address space
    prog[14] = 32'h0000_0E0E; prog[15] = 32'h0000_0F0F;
    prog[0]  = 32'h0000_1010; prog[1]  = 32'h8000_1111;
    p0 = pops; d0 = dones;
    launch(32'hFFFF_FFF8, 4, 4);
    wait_idle("t5", 40);
    check("t5_pops", pops - p0, 4);
    check("t5_dones", dones - d0, 1);
    scoreboard_empty("t5");

    // 6: asynchronous reset mid-FETCH, then a normal program
    for (int i = 0; i < 8; i++) prog[i] = 32'h0000_0600 + 32'(i);
    launch(32'h600, 8, 8);
    repeat (3) @(negedge clk);
    #3;
    rst = 1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_valid", instr_valid, 0);
    check("mid_rst_instr", instr, 0);
    check("mid_rst_done", done, 0);
    exp_addr.delete();
    exp_instr.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    load_t1();
    p0 = pops; d0 = dones;
    launch(32'h100, 4, 4);
    wait_idle("t6", 40);
    check("t6_pops", pops - p0, 4);
    check("t6_dones", dones - d0, 1);
    scoreboard_empty("t6");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    check("global_timeout", busy, ~busy);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit reached");
  end

endmodule
